// File: rtl/freq_pkg.sv
// Shared state encoding and default sizing for the frequency meter.
package freq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  localparam int CNT_W_DEF    = 16;
  localparam int LOCK_CNT_DEF = 4;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a history flop
// that turns the synchronised level into single-cycle rise/fall pulses.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~prev_p2;
  assign fall = ~sync_p1 & prev_p2;

endmodule

// File: rtl/freq_meter.sv
// Measures high/low time and period of a slow square wave in clk cycles,
// recovers the divide ratio, detects a stable period and flags a stalled input.
module freq_meter
  import freq_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic [CNT_W:0]   period,
  output logic [CNT_W-1:0] div_n,
  output logic             sym,
  output logic             meas_valid,
  output logic             locked,
  output logic             no_signal
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               MC_W    = $clog2(LOCK_CNT + 1);
  localparam logic [MC_W-1:0]  MC_LOCK = MC_W'(LOCK_CNT);
  localparam logic [MC_W-1:0]  MC_ONE  = MC_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic             rise;
  logic             fall;
  logic             any_edge;
  logic             stall_hit;
  logic             meas;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] hcnt_d;
  logic [CNT_W-1:0] lcnt_q;
  logic [CNT_W-1:0] lcnt_d;
  logic [CNT_W-1:0] shadow_q;
  logic [CNT_W-1:0] shadow_d;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;
  logic [MC_W-1:0]  match_q;
  logic [MC_W-1:0]  match_inc;
  logic [CNT_W:0]   new_period;

  // Front end: synchroniser and edge pulses (3-cycle latency for both edges)
  sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .rise (rise),
    .fall (fall)
  );

  assign any_edge  = rise | fall;
  assign stall_d   = any_edge ? '0 : sat_inc(stall_q);
  // Stays asserted every cycle the counter sits at saturation.
  assign stall_hit = ~any_edge & (stall_d == CNT_MAX);

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    lcnt_d   = lcnt_q;
    shadow_d = shadow_q;
    meas     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) state_d = ARMED;
      end
      ARMED: begin
        if (rise) begin
          hcnt_d  = CNT_W'(1);
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          shadow_d = hcnt_q;
          lcnt_d   = CNT_W'(1);
          state_d  = LOW;
        end else begin
          hcnt_d = sat_inc(hcnt_q);
        end
      end
      LOW: begin
        if (rise) begin
          meas    = 1'b1;
          hcnt_d  = CNT_W'(1);
          state_d = HIGH;
        end else begin
          lcnt_d = sat_inc(lcnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
    if (stall_hit) state_d = IDLE;
  end

  // Stage: FSM and counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      lcnt_q   <= '0;
      shadow_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      lcnt_q   <= lcnt_d;
      shadow_q <= shadow_d;
      stall_q  <= stall_d;
    end
  end

  assign new_period = {1'b0, shadow_q} + {1'b0, lcnt_q};
  assign match_inc  = (match_q == MC_LOCK) ? match_q : match_q + 1'b1;

  // Stage: measurement output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      high_time  <= '0;
      low_time   <= '0;
      period     <= '0;
      div_n      <= '0;
      sym        <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= meas;
      if (meas) begin
        high_time <= shadow_q;
        low_time  <= lcnt_q;
        period    <= new_period;
        div_n     <= shadow_q - CNT_W'(1);
        sym       <= (shadow_q == lcnt_q);
      end
    end
  end

  // Stage: lock tracking and stall flag
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q   <= '0;
      locked    <= 1'b0;
      no_signal <= 1'b0;
    end else begin
      if (stall_hit) begin
        match_q <= '0;
        locked  <= 1'b0;
      end else if (meas) begin
        if (new_period == period) begin
          match_q <= match_inc;
          locked  <= (match_inc >= MC_LOCK);
        end else begin
          match_q <= MC_ONE;
          locked  <= (MC_ONE >= MC_LOCK);
        end
      end
      if (any_edge) begin
        no_signal <= 1'b0;
      end else if (stall_hit) begin
        no_signal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: table rows of square waves, hand-written corner
// sequences and random edge spacing, all checked against an edge-time model.
module tb_freq_meter;

  localparam int CW   = 4;
  localparam int LOCK = 4;
  localparam int SAT  = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          sig_in;
  logic [CW-1:0] high_time;
  logic [CW-1:0] low_time;
  logic [CW:0]   period;
  logic [CW-1:0] div_n;
  logic          sym;
  logic          meas_valid;
  logic          locked;
  logic          no_signal;

  freq_meter #(.CNT_W(CW), .LOCK_CNT(LOCK)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .high_time  (high_time),
    .low_time   (low_time),
    .period     (period),
    .div_n      (div_n),
    .sym        (sym),
    .meas_valid (meas_valid),
    .locked     (locked),
    .no_signal  (no_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int hi; int lo; int reps;
    int e_high; int e_low; int e_period; int e_div; int e_sym; int lock_at;
  } vec_t;

  int checks;
  int errors;

  // Reference model: the input as seen two samples late, edge times, lock count
  int            k;
  logic          a1, a2, a3;
  int            n_edges, t_rise, t_fall, last_ref, mc;
  logic [CW-1:0] e_high, e_low, e_div;
  logic [CW:0]   e_period;
  logic          e_sym, e_mv, e_locked, e_nosig;

  vec_t rows [5];
  vec_t rv;
  logic row_mode;
  int   pulse_n;
  int   pq_per[$];
  int   pq_lck[$];
  int   pq_hi[$];
  int   pq_lo[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic model_step(input logic x, input logic r);
    logic cur, prv;
    int   hi, lo;
    k++;
    e_mv = 1'b0;
    if (r) begin
      a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
      e_high = '0; e_low = '0; e_period = '0; e_div = '0;
      e_sym = 1'b0; e_locked = 1'b0; e_nosig = 1'b0;
      n_edges = 0; mc = 0; last_ref = k;
    end else begin
      cur = a2;
      prv = a3;
      if (cur != prv) begin
        last_ref = k;
        e_nosig  = 1'b0;
        if (cur && n_edges >= 3) begin
          hi = t_fall - t_rise;
          lo = k - t_fall;
          if (hi + lo == int'(e_period)) mc = (mc < LOCK) ? mc + 1 : mc;
          else mc = 1;
          e_locked = (mc >= LOCK);
          e_high   = CW'(hi);
          e_low    = CW'(lo);
          e_period = (CW+1)'(hi + lo);
          e_div    = CW'(hi - 1);
          e_sym    = (hi == lo);
          e_mv     = 1'b1;
        end
        if (cur) t_rise = k;
        else t_fall = k;
        if (n_edges < 8) n_edges++;
      end else if (k - last_ref >= SAT) begin
        e_nosig  = 1'b1;
        e_locked = 1'b0;
        n_edges  = 0;
        mc       = 0;
      end
      a3 = a2; a2 = a1; a1 = x;
    end
  endtask

  task automatic check_outs();
    logic [4*CW+4:0] got, exp;
    got = {high_time, low_time, period, div_n, sym, meas_valid, locked, no_signal};
    exp = {e_high, e_low, e_period, e_div, e_sym, e_mv, e_locked, e_nosig};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model cyc=%0d got=%h expected=%h", k, got, exp);
    end
  endtask

  task automatic tick(input logic x);
    sig_in = x;
    @(posedge clk);
    model_step(x, rst);
    #1;
    check_outs();
  endtask

  task automatic on_pulse();
    pulse_n++;
    pq_per.push_back(int'(period));
    pq_lck.push_back(int'(locked));
    pq_hi.push_back(int'(high_time));
    pq_lo.push_back(int'(low_time));
    if (row_mode) begin
      chk("row_high", high_time, rv.e_high);
      chk("row_low", low_time, rv.e_low);
      chk("row_period", period, rv.e_period);
      chk("row_div", div_n, rv.e_div);
      chk("row_sym", sym, rv.e_sym);
      chk("row_locked", locked, (pulse_n >= rv.lock_at) ? 1 : 0);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      tick(lvl);
      if (meas_valid) on_pulse();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0); tick(1'b0); tick(1'b0);
    rst = 1'b0;
  endtask

  task automatic clear_pulses();
    pulse_n = 0;
    pq_per.delete(); pq_lck.delete(); pq_hi.delete(); pq_lo.delete();
  endtask

  initial begin
    int   exp_per[11];
    int   exp_lck[11];
    int   first_ns;
    int   len;
    int   pick;
    logic lvl;

    checks = 0; errors = 0; k = 0;
    a1 = 0; a2 = 0; a3 = 0;
    n_edges = 0; t_rise = 0; t_fall = 0; last_ref = 0; mc = 0;
    e_high = '0; e_low = '0; e_period = '0; e_div = '0;
    e_sym = 0; e_mv = 0; e_locked = 0; e_nosig = 0;
    row_mode = 1'b0;
    rst = 1'b1; sig_in = 1'b0;
    clear_pulses();

    rows[0] = '{4, 4, 7, 4, 4, 8,  3, 1, 4};
    rows[1] = '{3, 5, 6, 3, 5, 8,  2, 0, 4};
    rows[2] = '{1, 1, 6, 1, 1, 2,  0, 1, 4};
    rows[3] = '{6, 6, 4, 6, 6, 12, 5, 1, 4};
    rows[4] = '{2, 7, 5, 2, 7, 9,  1, 0, 4};
    exp_per = '{8, 8, 8, 8, 8, 12, 12, 12, 12, 12, 12};
    exp_lck = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1};

    do_reset();
    chk("reset_period", period, 0);
    chk("reset_locked", locked, 0);
    chk("reset_no_signal", no_signal, 0);

    // Table rows: each starts from reset with the input low
    for (int r = 0; r < 5; r++) begin
      rv = rows[r];
      do_reset();
      clear_pulses();
      row_mode = 1'b1;
      for (int p = 0; p < rv.reps; p++) begin
        drive(1'b1, rv.hi);
        drive(1'b0, rv.lo);
      end
      drive(1'b1, rv.hi);
      drive(1'b0, 4);
      row_mode = 1'b0;
      chk("row_pulses", pulse_n, rv.reps - 1);
    end

    // Period change 8 -> 12 while locked
    do_reset();
    clear_pulses();
    for (int p = 0; p < 6; p++) begin drive(1'b1, 4); drive(1'b0, 4); end
    for (int p = 0; p < 6; p++) begin drive(1'b1, 6); drive(1'b0, 6); end
    drive(1'b1, 6);
    drive(1'b0, 4);
    chk("chg_pulses", pulse_n, 11);
    for (int i = 0; i < 11 && i < pulse_n; i++) begin
      chk("chg_period", pq_per[i], exp_per[i]);
      chk("chg_locked", pq_lck[i], exp_lck[i]);
    end

    // Frozen input, then resume
    do_reset();
    clear_pulses();
    for (int p = 0; p < 6; p++) begin drive(1'b1, 4); drive(1'b0, 4); end
    drive(1'b1, 4);
    chk("pre_stall_locked", locked, 1);
    first_ns = 0;
    for (int i = 1; i <= 25; i++) begin
      tick(1'b0);
      if (no_signal && first_ns == 0) begin
        first_ns = i;
        chk("stall_locked", locked, 0);
        chk("stall_period_held", period, 8);
        chk("stall_high_held", high_time, 4);
      end
    end
    chk("stall_cycles", first_ns, 18);
    clear_pulses();
    tick(1'b1); tick(1'b1);
    chk("ns_before_edge", no_signal, 1);
    tick(1'b1);
    chk("ns_cleared", no_signal, 0);
    drive(1'b1, 1);
    drive(1'b0, 4); drive(1'b1, 4); drive(1'b0, 4); drive(1'b1, 4); drive(1'b0, 4);
    chk("resume_pulses", pulse_n, 1);
    if (pulse_n >= 1) begin
      chk("resume_high", pq_hi[0], 4);
      chk("resume_low", pq_lo[0], 4);
      chk("resume_locked", pq_lck[0], 0);
    end

    // Reset while in HIGH, released with the input high
    do_reset();
    clear_pulses();
    drive(1'b0, 2); drive(1'b1, 3); drive(1'b0, 3); drive(1'b1, 5);
    rst = 1'b1;
    tick(1'b1); tick(1'b1); tick(1'b1);
    rst = 1'b0;
    chk("rst_high_period", period, 0);
    chk("rst_high_mv", meas_valid, 0);
    chk("rst_high_ht", high_time, 0);
    drive(1'b1, 3); drive(1'b0, 4); drive(1'b1, 4); drive(1'b0, 4); drive(1'b1, 4); drive(1'b0, 4);
    chk("rst_high_pulses", pulse_n, 1);
    if (pulse_n >= 1) begin
      chk("rst_high_first_hi", pq_hi[0], 4);
      chk("rst_high_first_lo", pq_lo[0], 4);
      chk("rst_high_first_per", pq_per[0], 8);
    end

    // Random edge spacing, including gaps around the stall limit and resets
    do_reset();
    clear_pulses();
    lvl = 1'b0;
    for (int s = 0; s < 120; s++) begin
      pick = $urandom_range(0, 19);
      if (pick == 0) begin
        rst = 1'b1;
        tick(lvl); tick(lvl);
        rst = 1'b0;
      end
      if (pick <= 2) len = $urandom_range(14, 18);
      else len = $urandom_range(1, 8);
      lvl = ~lvl;
      drive(lvl, len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
